// File: rtl/qpix_pkg.sv
// qpix_pkg: shared QPix types and defaults for the serial-interface blocks
package qpix_pkg;

    localparam int QPIX_NBITS = 32;

    typedef enum logic [2:0] {
        RB_IDLE,
        RB_ARM,
        RB_HIGH,
        RB_LOW,
        RB_DONE,
        RB_PULSE,
        RB_LOW1
    } qpix_rb_state_t;

endpackage

// File: rtl/qpix_sync_bit.sv
// qpix_sync_bit: multi-flop synchroniser for a single asynchronous ASIC input
module qpix_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift the async level through the flop chain
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/qpix_readback_rx.sv
// qpix_readback_rx: clocks NBITS bits out of the ASIC config chain and captures them MSB-first
module qpix_readback_rx
    import qpix_pkg::*;
#(
    parameter int NBITS       = QPIX_NBITS,
    parameter int HALF_PER    = 25,
    parameter int SETUP_CYC   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             single_pulse,
    input  logic             serial_in,
    output logic             clkin2_out,
    output logic             serial_out_cnt,
    output logic             busy,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid
);

    // the phase counter also times the ARM setup window, so size it for the longer of the two
    localparam int CW = $clog2(HALF_PER > SETUP_CYC ? HALF_PER : SETUP_CYC) + 1;
    localparam int BW = $clog2(NBITS) + 1;

    qpix_rb_state_t   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bits_q, bits_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [NBITS-1:0] data_q;
    logic             start_q, pulse_q;
    logic             clk_q, soc_q, busy_q, valid_q;
    logic             start_req, pulse_req, sin, half_done;

    qpix_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (serial_in),
        .q_o   (sin)
    );

    // next-state, counters and shift register; requests only act from IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bits_d    = bits_q;
        sr_d      = sr_q;
        start_req = start & ~start_q;
        pulse_req = single_pulse & ~pulse_q;
        half_done = cnt_q == CW'(HALF_PER - 1);
        case (state_q)
            RB_IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    state_d = RB_ARM;
                    bits_d  = '0;
                end else if (pulse_req) begin
                    state_d = RB_PULSE;
                end
            end
            RB_ARM: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = RB_HIGH;
                    cnt_d   = '0;
                end
            end
            RB_HIGH: begin
                if (half_done) begin
                    state_d = RB_LOW;
                    cnt_d   = '0;
                    sr_d    = {sr_q[NBITS-2:0], sin};
                    bits_d  = bits_q + 1'b1;
                end
            end
            RB_LOW: begin
                if (half_done) begin
                    state_d = (bits_q < BW'(NBITS)) ? RB_HIGH : RB_DONE;
                    cnt_d   = '0;
                end
            end
            RB_DONE: begin
                state_d = RB_IDLE;
                cnt_d   = '0;
            end
            RB_PULSE: begin
                if (half_done) begin
                    state_d = RB_LOW1;
                    cnt_d   = '0;
                end
            end
            RB_LOW1: begin
                if (half_done) begin
                    state_d = RB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // state register; outputs are decoded from the next state so they line up with it glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RB_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            pulse_q <= 1'b0;
            clk_q   <= 1'b0;
            soc_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            sr_q    <= sr_d;
            start_q <= start;
            pulse_q <= single_pulse;
            clk_q   <= state_d == RB_HIGH || state_d == RB_PULSE;
            soc_q   <= state_d == RB_ARM || state_d == RB_HIGH || state_d == RB_LOW;
            busy_q  <= state_d != RB_IDLE;
            valid_q <= state_d == RB_DONE;
            if (state_d == RB_DONE) data_q <= sr_q;
        end
    end

    assign clkin2_out     = clk_q;
    assign serial_out_cnt = soc_q;
    assign busy           = busy_q;
    assign data_out       = data_q;
    assign data_valid     = valid_q;

endmodule
